// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: boot delay, stall,
// branch/jump/call/return redirects, halt/resume and a return-address stack.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus1,
  output logic              fetch_valid,
  output logic              halted,
  output logic              error,
  output logic [2:0]        stack_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam int unsigned SP_W      = $clog2(STACK_DEPTH);
  // A boot length of zero behaves like one cycle.
  localparam int unsigned BOOT_LAST = (BOOT_CYCLES > 1) ? BOOT_CYCLES - 1 : 0;
  localparam int unsigned BC_W      = (BOOT_LAST > 0) ? $clog2(BOOT_LAST + 1) : 1;
  localparam logic [2:0]  DEPTH     = 3'(STACK_DEPTH);

  state_t            state;
  logic [BC_W-1:0]   boot_cnt;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   push_idx;
  logic [SP_W-1:0]   pop_idx;

  assign pc_plus1    = pc + ADDR_W'(1);
  assign fetch_valid = (state == RUN) && !stall;

  always_comb begin
    push_idx = stack_count[SP_W-1:0];
    pop_idx  = SP_W'(stack_count - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      boot_cnt    <= '0;
      pc          <= ADDR_W'(RESET_PC);
      halted      <= 1'b0;
      error       <= 1'b0;
      stack_count <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          if (boot_cnt == BC_W'(BOOT_LAST)) state <= RUN;
          else                              boot_cnt <= boot_cnt + BC_W'(1);
        end
        RUN: begin
          // Faults park the PC on the offending instruction.
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (stall) begin
            state <= RUN;
          end else if (ret) begin
            if (stack_count != '0) begin
              pc          <= stack_mem[pop_idx];
              stack_count <= stack_count - 3'd1;
            end else begin
              error  <= 1'b1;
              state  <= HALT;
              halted <= 1'b1;
            end
          end else if (call) begin
            if (stack_count < DEPTH) begin
              stack_mem[push_idx] <= pc_plus1;
              pc                  <= target;
              stack_count         <= stack_count + 3'd1;
            end else begin
              error  <= 1'b1;
              state  <= HALT;
              halted <= 1'b1;
            end
          end else if (jump || branch_taken) begin
            pc <= target;
          end else begin
            pc <= pc_plus1;
          end
        end
        HALT: begin
          if (resume && !error) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
